datawidthconv_wide_to_narrow: RTL and testbench

Parametrised packet width converter. It buffers one packet of IN_W-bit stream beats, then drains it as OUT_W-bit writes with byte addresses starting at a per-packet base address. It sits between the wide packet sink and the narrow data memory / register write port. Unlike the fixed 512-to-32 converter, it adds source backpressure, output stall, actual-length draining, a per-packet base address and overflow reporting.

---
 rtl/datawidthconv_wide_to_narrow.sv | 190 +++++++++++++++++++
 tb/tb_datawidthconv_wide_to_narrow.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datawidthconv_wide_to_narrow.sv
`default_nettype none
// ============================================================================
// Module   : datawidthconv_wide_to_narrow
// Purpose  : Buffers one packet of IN_W-bit stream beats and drains it as
//            OUT_W-bit addressed writes. Lanes go out LSB first, starting at a
//            per-packet base address. Supports source backpressure, output
//            stall, actual-length draining and sticky overflow reporting.
// Revision : 1.0 - initial release
// ============================================================================
module datawidthconv_wide_to_narrow #(
    parameter int IN_W       = 512,
    parameter int OUT_W      = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    // wide packet sink
    input  logic              snk_sop,
    input  logic              snk_eop,
    input  logic              snk_valid,
    output logic              snk_ready,
    input  logic [IN_W-1:0]   snk_din,
    input  logic [ADDR_W-1:0] base_addr,
    // narrow write port
    output logic [ADDR_W-1:0] data_addr,
    output logic [OUT_W-1:0]  data_din,
    output logic              data_we,
    input  logic              data_ready,
    // status
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int c_RATIO  = IN_W / OUT_W;
    localparam int c_BYTES  = OUT_W / 8;
    localparam int c_DEPTH  = 1 << DEPTH_LOG2;
    localparam int c_LANE_W = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;

    localparam logic [DEPTH_LOG2:0]  c_DEPTH_CNT = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0]  c_ONE_CNT   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [c_LANE_W-1:0]  c_LAST_LANE = c_LANE_W'(c_RATIO - 1);
    localparam logic [c_LANE_W-1:0]  c_ONE_LANE  = c_LANE_W'(1);
    localparam logic [ADDR_W-1:0]    c_ADDR_STEP = ADDR_W'(c_BYTES);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [IN_W-1:0]     r_mem [c_DEPTH];
    logic                r_snk_ready;
    logic                r_in_pkt;     // a sop has been accepted for the packet being filled
    logic                r_overflow;
    logic                r_we;
    logic                r_done;
    logic [DEPTH_LOG2:0] r_count;      // beats stored so far (saturates at DEPTH)
    logic [DEPTH_LOG2:0] r_nbeats;     // beats to drain
    logic [DEPTH_LOG2:0] r_rd_beat;    // next buffer beat to fetch
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_addr;
    logic [IN_W-1:0]     r_shift;      // current beat, shifted so the active lane sits at the bottom
    logic [c_LANE_W-1:0] r_lane;

    logic                  w_accept;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_pkt_eop;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic [DEPTH_LOG2:0]   w_eop_nbeats;
    logic                  w_advance;

    // snk_ready is only ever high in FILL, so a handshake implies FILL
    assign w_accept  = snk_valid & r_snk_ready;
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_wr_en   = w_accept & (snk_sop | (r_in_pkt & ~w_full));
    assign w_wr_idx  = snk_sop ? '0 : r_count[DEPTH_LOG2-1:0];
    assign w_pkt_eop = w_accept & snk_eop & (snk_sop | r_in_pkt);
    assign w_advance = r_we & data_ready;

    // Beats counted including the eop beat, clamped to the buffer depth
    assign w_eop_nbeats = snk_sop ? c_ONE_CNT :
                          w_full  ? c_DEPTH_CNT : (r_count + c_ONE_CNT);

    assign snk_ready = r_snk_ready;
    assign data_addr = r_addr;
    assign data_din  = r_shift[OUT_W-1:0];
    assign data_we   = r_we;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign busy      = (r_state != S_FILL);

    // Packet buffer write; contents need no reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= snk_din;
        end
    end

    // Fill / drain / done sequencer with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_FILL;
            r_snk_ready <= 1'b0;
            r_in_pkt    <= 1'b0;
            r_overflow  <= 1'b0;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
            r_nbeats    <= '0;
            r_rd_beat   <= '0;
            r_base      <= '0;
            r_addr      <= '0;
            r_shift     <= '0;
            r_lane      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_FILL: begin
                    r_snk_ready <= 1'b1;
                    if (w_accept) begin
                        if (snk_sop) begin
                            // sop always (re)starts a packet, discarding earlier beats
                            r_base     <= base_addr;
                            r_count    <= c_ONE_CNT;
                            r_overflow <= 1'b0;
                            r_in_pkt   <= 1'b1;
                        end else if (r_in_pkt) begin
                            if (w_full) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_count <= r_count + c_ONE_CNT;
                            end
                        end
                        if (w_pkt_eop) begin
                            r_nbeats    <= w_eop_nbeats;
                            r_in_pkt    <= 1'b0;
                            r_rd_beat   <= '0;
                            r_snk_ready <= 1'b0;
                            r_state     <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (!r_we) begin
                        // first drain cycle: fetch beat 0 (one-cycle read)
                        r_shift   <= r_mem[r_rd_beat[DEPTH_LOG2-1:0]];
                        r_rd_beat <= r_rd_beat + c_ONE_CNT;
                        r_lane    <= '0;
                        r_addr    <= r_base;
                        r_we      <= 1'b1;
                    end else if (w_advance) begin
                        r_addr <= r_addr + c_ADDR_STEP;
                        if (r_lane == c_LAST_LANE) begin
                            if (r_rd_beat == r_nbeats) begin
                                r_we    <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                // next beat fetched while the last lane is on the port,
                                // so consecutive beats leave no bubble
                                r_shift   <= r_mem[r_rd_beat[DEPTH_LOG2-1:0]];
                                r_rd_beat <= r_rd_beat + c_ONE_CNT;
                                r_lane    <= '0;
                            end
                        end else begin
                            r_shift <= r_shift >> OUT_W;
                            r_lane  <= r_lane + c_ONE_LANE;
                        end
                    end
                end

                S_DONE: begin
                    r_snk_ready <= 1'b1;
                    r_state     <= S_FILL;
                end

                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_datawidthconv_wide_to_narrow.sv
`default_nettype none
// ============================================================================
// Module   : tb_datawidthconv_wide_to_narrow
// Purpose  : Randomised scoreboard bench for the wide-to-narrow converter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_datawidthconv_wide_to_narrow;

    localparam int IN_W       = 512;
    localparam int OUT_W      = 32;
    localparam int DEPTH_LOG2 = 5;
    localparam int ADDR_W     = 32;
    localparam int RATIO      = IN_W / OUT_W;
    localparam int BYTES      = OUT_W / 8;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              snk_sop = 1'b0;
    logic              snk_eop = 1'b0;
    logic              snk_valid = 1'b0;
    logic              snk_ready;
    logic [IN_W-1:0]   snk_din = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] data_addr;
    logic [OUT_W-1:0]  data_din;
    logic              data_we;
    logic              data_ready = 1'b1;
    logic              busy;
    logic              done;
    logic              overflow;

    datawidthconv_wide_to_narrow #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH_LOG2(DEPTH_LOG2), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_valid(snk_valid),
        .snk_ready(snk_ready), .snk_din(snk_din), .base_addr(base_addr),
        .data_addr(data_addr), .data_din(data_din), .data_we(data_we),
        .data_ready(data_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [OUT_W-1:0]  data;
    } word_t;

    word_t exp_q[$];
    bit    ovf_q[$];
    int    lat_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    ready_rand = 1'b0;

    // reference model state
    bit                m_in_pkt = 1'b0;
    logic [IN_W-1:0]   m_beats[$];
    logic [ADDR_W-1:0] m_base = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [IN_W-1:0] rand_beat();
        logic [IN_W-1:0] r;
        for (int i = 0; i < IN_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Packet-level model: collect accepted beats, expand into words on eop
    task automatic model_accept(bit sop, bit eop, logic [IN_W-1:0] d, logic [ADDR_W-1:0] b);
        int              nb;
        logic [IN_W-1:0] bt;
        word_t           w;
        if (sop) begin
            m_in_pkt = 1'b1;
            m_beats.delete();
            m_base = b;
        end else if (!m_in_pkt) begin
            return;
        end
        m_beats.push_back(d);
        if (eop) begin
            nb = (m_beats.size() > DEPTH) ? DEPTH : m_beats.size();
            for (int k = 0; k < nb; k++) begin
                bt = m_beats[k];
                for (int j = 0; j < RATIO; j++) begin
                    w.data = bt[OUT_W*j +: OUT_W];
                    w.addr = m_base + ADDR_W'((k * RATIO + j) * BYTES);
                    exp_q.push_back(w);
                end
            end
            ovf_q.push_back(m_beats.size() > DEPTH);
            lat_q.push_back(cyc + 2);
            m_in_pkt = 1'b0;
        end
    endtask

    // Input monitor: feeds the model with every accepted beat
    always @(negedge clk) begin
        if (reset_n) begin
            if (snk_valid && busy) check("ready_while_busy", 64'(snk_ready), 64'd0);
            if (snk_valid && snk_ready) model_accept(snk_sop, snk_eop, snk_din, base_addr);
        end
    end

    // Output monitor: scoreboard compare, stall stability, latency, done
    bit                stall_pend = 1'b0;
    bit                prev_we = 1'b0;
    logic [ADDR_W-1:0] held_addr;
    logic [OUT_W-1:0]  held_din;

    always @(negedge clk) begin
        word_t w;
        if (!reset_n) begin
            stall_pend = 1'b0;
            prev_we    = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_we", 64'(data_we), 64'd1);
                check("stall_addr", 64'(data_addr), 64'(held_addr));
                check("stall_din", 64'(data_din), 64'(held_din));
            end
            if (data_we && !prev_we) begin
                if (lat_q.size() == 0) fail_now("first_we_unexpected");
                else check("first_we_cycle", 64'(cyc), 64'(lat_q.pop_front()));
            end
            if (data_we && data_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    w = exp_q.pop_front();
                    check("word_addr", 64'(data_addr), 64'(w.addr));
                    check("word_data", 64'(data_din), 64'(w.data));
                end
            end
            if (done) begin
                check("done_we", 64'(data_we), 64'd0);
                check("done_busy", 64'(busy), 64'd1);
                check("words_left_at_done", 64'(exp_q.size()), 64'd0);
                if (ovf_q.size() == 0) fail_now("unexpected_done");
                else check("overflow_at_done", 64'(overflow), 64'(ovf_q.pop_front()));
            end
            stall_pend = data_we && !data_ready;
            held_addr  = data_addr;
            held_din   = data_din;
            prev_we    = data_we;
        end
    end

    // Output-side backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            data_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Present one beat from posedge+1 and hold it until accepted
    task automatic send_beat(bit sop, bit eop, logic [ADDR_W-1:0] b);
        bit acc = 1'b0;
        int guard = 0;
        snk_valid = 1'b1;
        snk_sop   = sop;
        snk_eop   = eop;
        snk_din   = rand_beat();
        base_addr = b;
        while (!acc && guard < 5000) begin
            @(negedge clk);
            acc = snk_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) fail_now("beat_accept_timeout");
    endtask

    task automatic idle_src();
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
    endtask

    task automatic send_pkt(int n, logic [ADDR_W-1:0] b);
        for (int i = 0; i < n; i++) send_beat(i == 0, i == n - 1, b);
        idle_src();
    endtask

    task automatic wait_idle(string name);
        int g = 0;
        while ((busy || exp_q.size() != 0 || ovf_q.size() != 0) && g < 20000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 20000) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        exp_q.delete();
        ovf_q.delete();
        lat_q.delete();
        m_in_pkt = 1'b0;
        #1;
        check("rst_we", 64'(data_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_ready", 64'(snk_ready), 64'd0);
        check("rst_addr", 64'(data_addr), 64'd0);
        check("rst_din", 64'(data_din), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        apply_reset();
        repeat (2) @(posedge clk);
        #1;
        check("ready_after_reset", 64'(snk_ready), 64'd1);

        // beats before any sop are dropped
        send_beat(1'b0, 1'b0, 32'h40);
        send_beat(1'b0, 1'b1, 32'h40);
        idle_src();
        repeat (5) @(posedge clk);
        #1;
        check("pre_sop_busy", 64'(busy), 64'd0);

        // 4-beat packet, continuous ready
        send_pkt(4, 32'h100);
        wait_idle("pkt4_timeout");
        check("ready_after_done", 64'(snk_ready), 64'd1);

        // single sop+eop beat with address wrap
        send_pkt(1, 32'hFFFF_FFF8);
        wait_idle("wrap_timeout");

        // 2-beat packet with random stalls
        ready_rand = 1'b1;
        send_pkt(2, 32'h0000_2000);
        wait_idle("stall_timeout");

        // overflow: 40 beats into 32 deep, then a packet sent during the drain
        ready_rand = 1'b0;
        send_pkt(40, 32'h0001_0000);
        check("overflow_set", 64'(overflow), 64'd1);
        send_beat(1'b1, 1'b0, 32'h0003_0000);
        check("overflow_cleared", 64'(overflow), 64'd0);
        send_beat(1'b0, 1'b0, 32'h0003_0000);
        send_beat(1'b0, 1'b1, 32'h0003_0000);
        idle_src();
        wait_idle("ovf_timeout");

        // mid-packet sop restarts the packet
        send_beat(1'b1, 1'b0, 32'h500);
        send_beat(1'b0, 1'b0, 32'h500);
        send_beat(1'b1, 1'b0, 32'h700);
        send_beat(1'b0, 1'b1, 32'h700);
        idle_src();
        wait_idle("restart_timeout");

        // reset in the middle of a drain
        send_pkt(4, 32'h0000_8000);
        g = 0;
        while (!data_we && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_started", 64'(data_we), 64'd1);
        repeat (10) @(posedge clk);
        apply_reset();
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_busy", 64'(busy), 64'd0);
        send_pkt(3, 32'h0000_9000);
        wait_idle("post_reset_timeout");

        // random packets
        for (int p = 0; p < 6; p++) begin
            ready_rand = 1'($urandom_range(0, 1));
            send_pkt($urandom_range(1, 6), $urandom);
            wait_idle("random_timeout");
        end

        check("final_exp_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
